wb_xmem_slave: RTL and testbench

Wishbone B3 slave that answers the off-chip RAM window (0x01000000–0x017FFFFF) on the processor's exported external-memory master port. It translates each 32-bit Wishbone classic access into two 16-bit accesses on an asynchronous SRAM-style device. It has programmable wait states and byte-lane control. It sits outside the processor top, connected to the `sdr_bus` master port, with its memory pins going to the board.

---
 rtl/wb_xmem_slave_if.sv | 23 ++
 rtl/wb_xmem_slave.sv | 204 ++++++++++++++++++++
 tb/tb_wb_xmem_slave.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_xmem_slave_if.sv
// rtl/wb_xmem_slave_if.sv - Wishbone B3 bus bundle for the external-memory master port
interface wishbone_b3;
  logic        cyc;
  logic        stb;
  logic [31:0] adr;
  logic [31:0] dat_m2s;
  logic [3:0]  sel;
  logic        we;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat_s2m;
  logic        ack;

  modport master (
    output cyc, stb, adr, dat_m2s, sel, we, cti, bte,
    input  dat_s2m, ack
  );

  modport slave (
    input  cyc, stb, adr, dat_m2s, sel, we, cti, bte,
    output dat_s2m, ack
  );
endinterface

// File: rtl/wb_xmem_slave.sv
// rtl/wb_xmem_slave.sv - Wishbone B3 slave splitting 32-bit accesses into two 16-bit async SRAM phases
module wb_xmem_slave #(
  parameter int ADDR_WIDTH = 22,
  parameter int WAIT_RD    = 2,
  parameter int WAIT_WR    = 2,
  parameter int TURN       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  wishbone_b3.slave             bus,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_dq_o,
  input  logic [15:0]           mem_dq_i,
  output logic                  mem_dq_oe,
  output logic                  mem_ce_n,
  output logic                  mem_oe_n,
  output logic                  mem_we_n,
  output logic                  mem_ub_n,
  output logic                  mem_lb_n
);

  localparam logic [4:0] RD_LAST   = 5'(WAIT_RD);
  localparam logic [4:0] WR_LAST   = 5'(WAIT_WR + 1);
  localparam logic [4:0] WR_LOW    = 5'(WAIT_WR);
  localparam logic [4:0] TURN_LAST = 5'((TURN > 0) ? (TURN - 1) : 0);

  typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_ACK, S_TURN} state_t;
  typedef enum logic [2:0] {ST_NONE, ST_HOLD, ST_LO, ST_HI, ST_ACK, ST_END, ST_IDLE} step_t;

  state_t                state_q;
  logic [4:0]            cnt_q;
  logic [ADDR_WIDTH-2:0] word_q;
  logic [31:0]           dat_q;
  logic [3:0]            sel_q;
  logic                  we_q;
  logic                  abort_q;
  logic [15:0]           lo_q;
  logic                  ack_q;
  logic [31:0]           dat_s2m_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [15:0]           dq_o_q;
  logic                  dq_oe_q;
  logic                  ce_n_q;
  logic                  oe_n_q;
  logic                  we_n_q;
  logic                  ub_n_q;
  logic                  lb_n_q;

  // Request fields come straight from the bus while idle, from the latched copy afterwards
  logic                  src_we;
  logic [3:0]            src_sel;
  logic [31:0]           src_dat;
  logic [ADDR_WIDTH-2:0] src_word;
  logic                  lo_need;
  logic                  hi_need;
  logic                  phase_last;
  logic                  aborting;
  step_t                 step;
  logic                  entry_hi;
  logic [1:0]            entry_be;
  logic [15:0]           entry_dq;

  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus.adr[31:ADDR_WIDTH+1], bus.adr[1:0], bus.cti, bus.bte};

  // Decide what the next edge does: hold the phase, open a phase, acknowledge, or wind down
  always_comb begin
    src_we     = (state_q == S_IDLE) ? bus.we                   : we_q;
    src_sel    = (state_q == S_IDLE) ? bus.sel                  : sel_q;
    src_dat    = (state_q == S_IDLE) ? bus.dat_m2s              : dat_q;
    src_word   = (state_q == S_IDLE) ? bus.adr[ADDR_WIDTH:2]    : word_q;
    lo_need    = !src_we || (src_sel[1:0] != 2'b00);
    hi_need    = !src_we || (src_sel[3:2] != 2'b00);
    phase_last = we_q ? (cnt_q == WR_LAST) : (cnt_q == RD_LAST);
    aborting   = abort_q || !bus.cyc;
    step       = ST_NONE;
    case (state_q)
      S_IDLE: begin
        if (bus.cyc && bus.stb && !ack_q) begin
          if (lo_need)      step = ST_LO;
          else if (hi_need) step = ST_HI;
          else              step = ST_ACK;
        end
      end
      S_LO: begin
        if (!phase_last)  step = ST_HOLD;
        else if (aborting) step = ST_END;
        else if (hi_need) step = ST_HI;
        else              step = ST_ACK;
      end
      S_HI: begin
        if (!phase_last)   step = ST_HOLD;
        else if (aborting) step = ST_END;
        else               step = ST_ACK;
      end
      S_ACK:   step = ST_END;
      S_TURN:  step = (cnt_q == TURN_LAST) ? ST_IDLE : ST_HOLD;
      default: step = ST_IDLE;
    endcase
    entry_hi = (step == ST_HI);
    entry_be = entry_hi ? src_sel[3:2] : src_sel[1:0];
    entry_dq = entry_hi ? src_dat[31:16] : src_dat[15:0];
  end

  // Access sequencer with every bus and memory pin registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      word_q     <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      abort_q    <= 1'b0;
      lo_q       <= '0;
      ack_q      <= 1'b0;
      dat_s2m_q  <= '0;
      mem_addr_q <= '0;
      dq_o_q     <= '0;
      dq_oe_q    <= 1'b0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      ub_n_q     <= 1'b1;
      lb_n_q     <= 1'b1;
    end else begin
      ack_q <= 1'b0;
      if ((state_q == S_LO || state_q == S_HI) && !bus.cyc) begin
        abort_q <= 1'b1;
      end
      if (state_q == S_IDLE && step != ST_NONE) begin
        word_q  <= src_word;
        dat_q   <= src_dat;
        sel_q   <= src_sel;
        we_q    <= src_we;
        abort_q <= 1'b0;
      end
      case (step)
        ST_HOLD: begin
          cnt_q <= cnt_q + 5'd1;
          if ((state_q == S_LO || state_q == S_HI) && we_q) begin
            we_n_q <= !(cnt_q < WR_LOW);
          end
        end
        ST_LO, ST_HI: begin
          if (state_q == S_LO) begin
            lo_q <= mem_dq_i;
          end
          state_q    <= entry_hi ? S_HI : S_LO;
          cnt_q      <= '0;
          mem_addr_q <= {src_word, entry_hi};
          dq_o_q     <= entry_dq;
          dq_oe_q    <= src_we;
          ce_n_q     <= 1'b0;
          oe_n_q     <= src_we;
          we_n_q     <= 1'b1;
          lb_n_q     <= src_we ? !entry_be[0] : 1'b0;
          ub_n_q     <= src_we ? !entry_be[1] : 1'b0;
        end
        ST_ACK: begin
          if (state_q == S_HI && !we_q) begin
            dat_s2m_q <= {mem_dq_i, lo_q};
          end
          state_q <= S_ACK;
          ack_q   <= 1'b1;
          dq_oe_q <= 1'b0;
          ce_n_q  <= 1'b1;
          oe_n_q  <= 1'b1;
          we_n_q  <= 1'b1;
          lb_n_q  <= 1'b1;
          ub_n_q  <= 1'b1;
        end
        ST_END: begin
          state_q <= (TURN == 0) ? S_IDLE : S_TURN;
          cnt_q   <= '0;
          dq_oe_q <= 1'b0;
          ce_n_q  <= 1'b1;
          oe_n_q  <= 1'b1;
          we_n_q  <= 1'b1;
          lb_n_q  <= 1'b1;
          ub_n_q  <= 1'b1;
        end
        ST_IDLE: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.ack     = ack_q;
  assign bus.dat_s2m = dat_s2m_q;
  assign mem_addr    = mem_addr_q;
  assign mem_dq_o    = dq_o_q;
  assign mem_dq_oe   = dq_oe_q;
  assign mem_ce_n    = ce_n_q;
  assign mem_oe_n    = oe_n_q;
  assign mem_we_n    = we_n_q;
  assign mem_ub_n    = ub_n_q;
  assign mem_lb_n    = lb_n_q;

endmodule

// File: tb/tb_wb_xmem_slave.sv
// tb/tb_wb_xmem_slave.sv - self-checking bench for wb_xmem_slave
module tb_wb_xmem_slave;

  localparam int WRD_A = 2;
  localparam int WWR_A = 2;
  localparam int TRN_A = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wishbone_b3 wb_a();
  wishbone_b3 wb_b();

  logic [21:0] a_addr, b_addr;
  logic [15:0] a_dq_o, a_dq_i, b_dq_o, b_dq_i;
  logic        a_dq_oe, a_ce_n, a_oe_n, a_we_n, a_ub_n, a_lb_n;
  logic        b_dq_oe, b_ce_n, b_oe_n, b_we_n, b_ub_n, b_lb_n;

  wb_xmem_slave #(.ADDR_WIDTH(22), .WAIT_RD(WRD_A), .WAIT_WR(WWR_A), .TURN(TRN_A)) u_dut_a (
    .clk(clk), .rst(rst), .bus(wb_a),
    .mem_addr(a_addr), .mem_dq_o(a_dq_o), .mem_dq_i(a_dq_i), .mem_dq_oe(a_dq_oe),
    .mem_ce_n(a_ce_n), .mem_oe_n(a_oe_n), .mem_we_n(a_we_n), .mem_ub_n(a_ub_n), .mem_lb_n(a_lb_n)
  );

  wb_xmem_slave #(.ADDR_WIDTH(22), .WAIT_RD(0), .WAIT_WR(1), .TURN(0)) u_dut_b (
    .clk(clk), .rst(rst), .bus(wb_b),
    .mem_addr(b_addr), .mem_dq_o(b_dq_o), .mem_dq_i(b_dq_i), .mem_dq_oe(b_dq_oe),
    .mem_ce_n(b_ce_n), .mem_oe_n(b_oe_n), .mem_we_n(b_we_n), .mem_ub_n(b_ub_n), .mem_lb_n(b_lb_n)
  );

  // Pin-level SRAM for DUT A; DUT B sees a fixed address-derived pattern
  logic [15:0] sram [0:4095];
  bit          cleared = 1'b0;
  assign a_dq_i = (!a_ce_n && !a_oe_n) ? sram[a_addr[11:0]] : 16'hFFFF;
  assign b_dq_i = (!b_ce_n && !b_oe_n) ? (b_addr[15:0] ^ 16'h3C00) : 16'hFFFF;

  int   ce_low_total = 0;
  int   we_low_total = 0;
  int   viol = 0;
  logic last_lb_n = 1'b1;
  logic last_ub_n = 1'b1;
  logic prev_ack_a = 1'b0;
  logic prev_ack_b = 1'b0;

  always @(negedge clk) begin
    if (!cleared) begin
      for (int i = 0; i < 4096; i++) sram[i] <= 16'h0000;
      cleared <= 1'b1;
    end else if (!a_ce_n && !a_we_n) begin
      if (!a_lb_n) sram[a_addr[11:0]][7:0]  <= a_dq_o[7:0];
      if (!a_ub_n) sram[a_addr[11:0]][15:8] <= a_dq_o[15:8];
    end
  end

  always @(negedge clk) begin
    int v;
    v = 0;
    if (!a_we_n && !a_oe_n) v++;
    if (a_dq_oe && !a_oe_n) v++;
    if (wb_a.ack && prev_ack_a) v++;
    if (!b_we_n && !b_oe_n) v++;
    if (b_dq_oe && !b_oe_n) v++;
    if (wb_b.ack && prev_ack_b) v++;
    viol       <= viol + v;
    prev_ack_a <= wb_a.ack;
    prev_ack_b <= wb_b.ack;
    if (!a_ce_n) ce_low_total <= ce_low_total + 1;
    if (!a_we_n) begin
      we_low_total <= we_low_total + 1;
      last_lb_n    <= a_lb_n;
      last_ub_n    <= a_ub_n;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: word-addressed memory with byte-masked writes
  logic [31:0] ref_mem [0:1023];

  function automatic void ref_write(input int w, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++) begin
      if (s[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
    end
  endfunction

  function automatic int exp_lat(input logic we, input logic [3:0] s);
    int halves;
    if (!we) return 2 * (WRD_A + 1) + 1;
    halves = ((s[1:0] != 2'b00) ? 1 : 0) + ((s[3:2] != 2'b00) ? 1 : 0);
    return halves * (WWR_A + 2) + 1;
  endfunction

  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rdata, output int lat,
                      output int ce_cnt, output int we_cnt);
    int ce0, we0;
    ce0 = ce_low_total;
    we0 = we_low_total;
    wb_a.cyc = 1'b1; wb_a.stb = 1'b1; wb_a.we = we;
    wb_a.adr = adr;  wb_a.dat_m2s = dat; wb_a.sel = sel;
    lat   = -1;
    rdata = '0;
    for (int n = 1; n <= 64; n++) begin
      @(negedge clk);
      if (wb_a.ack) begin
        lat   = n;
        rdata = wb_a.dat_s2m;
        break;
      end
    end
    wb_a.cyc = 1'b0;
    wb_a.stb = 1'b0;
    repeat (TRN_A + 1) @(negedge clk);
    ce_cnt = ce_low_total - ce0;
    we_cnt = we_low_total - we0;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          lat;
    logic [31:0] rd;
    int          we_low;
    int          ce_low;
    bit          chk_be;
    logic        lb_n;
    logic        ub_n;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int          lat, cc, wc, acks, w;
    logic        we;
    logic [31:0] d;
    logic [3:0]  s;
    logic [11:0] ackv;
    logic [31:0] b_rd;
    bit          got, found;

    vecs[0] = '{1'b1, 32'h01000010, 32'hDEADBEEF, 4'hF, 9, 32'h0,        4, 8, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{1'b0, 32'h01000010, 32'h0,        4'hF, 7, 32'hDEADBEEF, 0, 6, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 32'h01000020, 32'hAAAAAAAA, 4'hF, 9, 32'h0,        4, 8, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 32'h01000020, 32'h11223344, 4'h4, 5, 32'h0,        2, 4, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 32'h01000020, 32'h0,        4'hF, 7, 32'hAA22AAAA, 0, 6, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 32'h01000030, 32'hCAFEF00D, 4'h0, 1, 32'h0,        0, 0, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 32'h01000030, 32'h0,        4'hF, 7, 32'h00000000, 0, 6, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 32'h01000040, 32'h12345678, 4'h3, 5, 32'h0,        2, 4, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 32'h01000040, 32'h0,        4'hF, 7, 32'h00005678, 0, 6, 1'b0, 1'b1, 1'b1};

    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    rst = 1'b0;
    wb_a.cyc = 0; wb_a.stb = 0; wb_a.we = 0; wb_a.adr = 0; wb_a.dat_m2s = 0; wb_a.sel = 0;
    wb_a.cti = 0; wb_a.bte = 0;
    wb_b.cyc = 0; wb_b.stb = 0; wb_b.we = 0; wb_b.adr = 0; wb_b.dat_m2s = 0; wb_b.sel = 0;
    wb_b.cti = 0; wb_b.bte = 0;
    repeat (3) @(negedge clk);

    check("reset_a_bus", 64'({wb_a.ack, wb_a.dat_s2m}), 64'h0);
    check("reset_a_pins", 64'({a_addr, a_dq_o, a_dq_oe, a_ce_n, a_oe_n, a_we_n, a_ub_n, a_lb_n}),
          64'({22'h0, 16'h0, 1'b0, 5'b11111}));
    check("reset_b_pins", 64'({wb_b.ack, b_dq_oe, b_ce_n, b_oe_n, b_we_n, b_ub_n, b_lb_n}),
          64'({1'b0, 1'b0, 5'b11111}));
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      xfer(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, rd, lat, cc, wc);
      if (vecs[i].we) ref_write(int'(vecs[i].adr[11:2]), vecs[i].dat, vecs[i].sel);
      check($sformatf("vec%0d_ack_cycle", i), 64'(lat), 64'(vecs[i].lat));
      if (!vecs[i].we) check($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].rd));
      check($sformatf("vec%0d_ce_low_cycles", i), 64'(cc), 64'(vecs[i].ce_low));
      check($sformatf("vec%0d_we_low_cycles", i), 64'(wc), 64'(vecs[i].we_low));
      if (vecs[i].chk_be)
        check($sformatf("vec%0d_byte_lanes", i), 64'({last_lb_n, last_ub_n}),
              64'({vecs[i].lb_n, vecs[i].ub_n}));
    end
    check("sram_hw8", 64'(sram[8]), 64'h BEEF);
    check("sram_hw9", 64'(sram[9]), 64'h DEAD);

    // Abort: cyc dropped in cycle 2 of a full write
    xfer(1'b1, 32'h01000050, 32'hAAAAAAAA, 4'hF, rd, lat, cc, wc);
    ref_write(20, 32'hAAAAAAAA, 4'hF);
    check("abort_prefill_ack", 64'(lat), 64'd9);
    wc   = we_low_total;
    acks = 0;
    wb_a.cyc = 1; wb_a.stb = 1; wb_a.we = 1; wb_a.adr = 32'h01000050;
    wb_a.dat_m2s = 32'h55667788; wb_a.sel = 4'hF;
    @(negedge clk); if (wb_a.ack) acks++;
    @(negedge clk); if (wb_a.ack) acks++;
    wb_a.cyc = 0; wb_a.stb = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (wb_a.ack) acks++;
    end
    check("abort_no_ack", 64'(acks), 64'd0);
    check("abort_we_pulse_len", 64'(we_low_total - wc), 64'(WWR_A));
    check("abort_lo_written", 64'(sram[40]), 64'h7788);
    check("abort_hi_untouched", 64'(sram[41]), 64'hAAAA);
    ref_write(20, 32'h55667788, 4'h3);

    // Asynchronous reset while mem_we_n is low
    wb_a.cyc = 1; wb_a.stb = 1; wb_a.we = 1; wb_a.adr = 32'h01000100;
    wb_a.dat_m2s = 32'h12345678; wb_a.sel = 4'hF;
    found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      @(negedge clk);
      if (!a_we_n) found = 1'b1;
    end
    check("rst_we_low_reached", 64'(found), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("rst_async_pins", 64'({a_we_n, a_dq_oe, a_ce_n, wb_a.ack}), 64'b1010);
    wb_a.cyc = 0; wb_a.stb = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    xfer(1'b0, 32'h01000000, 32'h0, 4'hF, rd, lat, cc, wc);
    check("post_rst_read_ack", 64'(lat), 64'd7);
    check("post_rst_read_data", 64'(rd), 64'(ref_mem[0]));
    ref_mem[64] = {sram[129], sram[128]};

    // Zero-wait, zero-turn DUT: back-to-back reads with stb held
    wb_b.cyc = 1; wb_b.stb = 1; wb_b.we = 0; wb_b.adr = 32'h01000014; wb_b.sel = 4'hF;
    ackv = '0;
    got  = 1'b0;
    b_rd = '0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      ackv[n-1] = wb_b.ack;
      if (wb_b.ack && !got) begin
        got  = 1'b1;
        b_rd = wb_b.dat_s2m;
      end
    end
    wb_b.cyc = 0; wb_b.stb = 0;
    check("b2b_ack_pattern", 64'(ackv), 64'b0100_0100_0100);
    check("b2b_read_data", 64'(b_rd), 64'h3C0B3C0A);
    repeat (3) @(negedge clk);

    // Randomized traffic against the reference model
    for (int k = 0; k < 150; k++) begin
      w  = int'($urandom_range(0, 1023));
      we = 1'($urandom_range(0, 1));
      d  = $urandom;
      s  = 4'($urandom_range(0, 15));
      wb_a.cti = 3'($urandom_range(0, 7));
      wb_a.bte = 2'($urandom_range(0, 3));
      xfer(we, 32'h01000000 + 32'(w) * 32'd4, d, s, rd, lat, cc, wc);
      check($sformatf("rand%0d_ack_cycle", k), 64'(lat), 64'(exp_lat(we, s)));
      if (!we) check($sformatf("rand%0d_rdata", k), 64'(rd), 64'(ref_mem[w]));
      else     ref_write(w, d, s);
    end

    check("strobe_invariants", 64'(viol), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
